// File: rtl/ysyx_ifq.sv
// Instruction fetch queue between fetch and decode: an in-order {pc, inst} FIFO flushed on redirect.
// Optional same-cycle bypass from fetch to decode when empty: define YSYX_IFQ_BYPASS_EN.
module ysyx_ifq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       prev_valid,
    output logic                       ready_o,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [DATA_W-1:0]          inst_i,
    output logic                       valid_o,
    input  logic                       next_ready,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [DATA_W-1:0]          inst_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             head_valid;
    logic             byp;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign ready_o    = rst & (count != CNT_W'(DEPTH));
    assign head_valid = rst & (count != '0);
    assign head       = mem[rd_ptr];
    assign count_o    = rst ? count : '0;

`ifdef YSYX_IFQ_BYPASS_EN
    assign byp = rst & (count == '0) & prev_valid & ~flush_i;
`else
    assign byp = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle is never written.
    assign push = prev_valid & ready_o & ~flush_i & ~(byp & next_ready);
    assign pop  = head_valid & next_ready & ~flush_i;

    always_comb begin
        valid_o = head_valid | byp;
        pc_o    = '0;
        inst_o  = '0;
        if (head_valid) begin
            pc_o   = head[ENT_W-1:DATA_W];
            inst_o = head[DATA_W-1:0];
        end else if (byp) begin
            pc_o   = pc_i;
            inst_o = inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pc_i, inst_i};
        end
    end

endmodule
